// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
// Word packing: lane l of column c lives at word l*arraySize + c.
package systolic_pkg;

    localparam int ARRAY_SIZE      = 2;
    localparam int LANES           = 4;
    localparam int OUTPUT_BITS     = 32;
    localparam int FIFO_DEPTH      = 8;
    localparam int ROWS_PER_PACKET = 2;
    localparam int TDATA_W         = ARRAY_SIZE * LANES * OUTPUT_BITS;
    localparam int CNT_W           = $clog2(FIFO_DEPTH + 1);

    typedef logic [TDATA_W-1:0] row_t;

    function automatic int word_idx(
        input int l,
        input int c,
        input int n = ARRAY_SIZE
    );
        return l * n + c;
    endfunction

endpackage

// File: rtl/dff.sv
// Plain register stage used by the deskew delay lines.
// Async active-low reset.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= '0;
        else      r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/row_fifo.sv
// Row FIFO with combinational read data and sticky overflow.
// A push into a full FIFO is accepted only when a pop frees a slot.
module row_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    assign w_wr    = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr && !i_clear) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign o_rdata    = r_mem[r_rptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/output_deskew_stream.sv
// Realigns skewed array columns into rows and streams them on AXIS.
// Column c is delayed arraySize-1-c cycles so all columns meet.
module output_deskew_stream
    import systolic_pkg::*;
#(
    parameter int arraySize         = 2,
    parameter int lanes             = 4,
    parameter int outputBits        = 32,
    parameter int fifoDepth         = 8,
    parameter int rowsPerPacket     = 2,
    parameter int m_axi_tdata_width = arraySize * lanes * outputBits,
    parameter int m_axi_tkeep_width = m_axi_tdata_width / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           arr_valid,
    input  logic [m_axi_tdata_width-1:0]   arr_data,
    output logic                           almost_full,
    output logic                           overflow,
    output logic [$clog2(fifoDepth+1)-1:0] count,
    output logic [m_axi_tdata_width-1:0]   M_AXIS_TDATA,
    output logic [m_axi_tkeep_width-1:0]   M_AXIS_TKEEP,
    output logic                           M_AXIS_TLAST,
    output logic                           M_AXIS_TVALID,
    input  logic                           M_AXIS_TREADY
);

    localparam int COL_W = lanes * outputBits;
    localparam int CW    = $clog2(fifoDepth + 1);
    localparam int BW    = (rowsPerPacket > 1) ? $clog2(rowsPerPacket) : 1;

    logic [arraySize-1:0]         w_vd;
    logic [m_axi_tdata_width-1:0] w_row;
    logic                         w_empty;
    logic                         w_full;
    logic                         w_hs;
    logic                         w_last;
    logic [BW-1:0]                r_beat;

    assign w_vd[0] = arr_valid;

    generate
        if (arraySize > 1) begin : g_vd
            logic [arraySize-1:1] r_vd;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)       r_vd <= '0;
                else if (clear) r_vd <= '0;
                else            r_vd <= w_vd[arraySize-2:0];
            end
            assign w_vd[arraySize-1:1] = r_vd;
        end
    endgenerate

    for (genvar c = 0; c < arraySize; c++) begin : g_col
        localparam int D = arraySize - 1 - c;
        logic [COL_W-1:0] w_in;
        logic [COL_W-1:0] w_dly [D+1];

        for (genvar l = 0; l < lanes; l++) begin : g_lane
            localparam int WI = word_idx(l, c, arraySize);
            assign w_in[l*outputBits +: outputBits] =
                arr_data[WI*outputBits +: outputBits];
            assign w_row[WI*outputBits +: outputBits] =
                w_dly[D][l*outputBits +: outputBits];
        end

        assign w_dly[0] = w_in;

        for (genvar s = 0; s < D; s++) begin : g_dly
            dff #(.W(COL_W)) u_dff (
                .clk (clk),
                .rst (rst),
                .i_d (w_dly[s]),
                .o_q (w_dly[s+1])
            );
        end
    end

    row_fifo #(
        .W     (m_axi_tdata_width),
        .DEPTH (fifoDepth)
    ) u_row_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clear),
        .i_push     (w_vd[arraySize-1]),
        .i_pop      (w_hs),
        .i_wdata    (w_row),
        .o_rdata    (M_AXIS_TDATA),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (count),
        .o_overflow (overflow)
    );

    assign M_AXIS_TVALID = !w_empty;
    assign w_hs          = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_last        = (r_beat == BW'(rowsPerPacket - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_beat <= '0;
        else if (clear) r_beat <= '0;
        else if (w_hs)  r_beat <= w_last ? '0 : r_beat + BW'(1);
    end

    // Headroom for rows still travelling through the deskew pipeline.
    assign almost_full  = (count >= CW'(fifoDepth - arraySize)) || w_full;
    assign M_AXIS_TLAST = M_AXIS_TVALID && w_last;
    assign M_AXIS_TKEEP = '1;

endmodule

// File: tb/tb_output_deskew_stream.sv
// Self-checking bench for output_deskew_stream.
// A queue model predicts FIFO contents, beat position and overflow.
module tb_output_deskew_stream;
    import systolic_pkg::*;

    localparam int N   = ARRAY_SIZE;
    localparam int L   = LANES;
    localparam int OB  = OUTPUT_BITS;
    localparam int D   = FIFO_DEPTH;
    localparam int RPP = ROWS_PER_PACKET;
    localparam int W   = TDATA_W;
    localparam int NW  = N * L;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             arr_valid = 1'b0;
    row_t             arr_data = '0;
    logic             almost_full;
    logic             overflow;
    logic [CNT_W-1:0] count;
    row_t             tdata;
    logic [W/8-1:0]   tkeep;
    logic             tlast;
    logic             tvalid;
    logic             tready = 1'b0;

    output_deskew_stream #(
        .arraySize     (N),
        .lanes         (L),
        .outputBits    (OB),
        .fifoDepth     (D),
        .rowsPerPacket (RPP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .arr_valid     (arr_valid),
        .arr_data      (arr_data),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .count         (count),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TKEEP  (tkeep),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    row_t mq[$];
    row_t pv_row [N];
    bit   pv_v [N];
    int   mbeat;
    bit   movf;
    row_t hist [N];
    bit   cur_v;

    typedef struct {
        bit v;
        int val;
        bit rdy;
        int cnt;
        bit af;
        bit ovf;
    } vec_t;
    vec_t tbl [18];

    function automatic row_t mk(input int v);
        row_t r;
        for (int w = 0; w < NW; w++) r[w*OB +: OB] = OB'(v * 256 + w);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive();
        row_t d;
        for (int w = 0; w < NW; w++)
            d[w*OB +: OB] = hist[w % N][w*OB +: OB];
        arr_data  = d;
        arr_valid = cur_v;
    endtask

    task automatic set_in(input bit v, input row_t r, input bit rdy);
        cur_v   = v;
        hist[0] = r;
        tready  = rdy;
        drive();
    endtask

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < N; i++) pv_v[i] = 1'b0;
        mbeat = 0;
        movf  = 1'b0;
    endtask

    task automatic tick();
        bit   mv;
        bit   hs;
        bit   land;
        row_t lr;
        @(negedge clk);
        mv = (mq.size() != 0);
        chk("tvalid", tvalid, mv);
        chk("count", count, mq.size());
        chk("overflow", overflow, movf);
        chk("almost_full", almost_full, mq.size() >= D - N);
        chk("tlast", tlast, mv && (mbeat == RPP - 1));
        if (mv) chk("tdata", tdata, mq[0]);
        hs = mv && tready;
        @(posedge clk);
        if (!rst || clear) begin
            model_clear();
        end else begin
            if (hs) begin
                void'(mq.pop_front());
                mbeat = (mbeat == RPP - 1) ? 0 : mbeat + 1;
            end
            land = pv_v[N-2];
            lr   = pv_row[N-2];
            for (int i = N - 2; i > 0; i--) begin
                pv_v[i]   = pv_v[i-1];
                pv_row[i] = pv_row[i-1];
            end
            pv_v[0]   = cur_v;
            pv_row[0] = hist[0];
            if (land) begin
                if (mq.size() < D) mq.push_back(lr);
                else movf = 1'b1;
            end
        end
        #1;
        for (int c = N - 1; c > 0; c--) hist[c] = hist[c-1];
        cur_v = 1'b0;
        drive();
    endtask

    task automatic drain();
        int n = 0;
        set_in(1'b0, '0, 1'b1);
        while ((mq.size() != 0 || pv_v[0]) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_count", count, 0);
        chk("drain_tvalid", tvalid, 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        row_t r;
        int   av [8];
        av = '{1, 5, 2, 6, 3, 7, 4, 8};

        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 1, 0, 0};
        tbl[2]  = '{1, 3, 0, 2, 0, 0};
        tbl[3]  = '{1, 4, 0, 3, 0, 0};
        tbl[4]  = '{1, 5, 0, 4, 0, 0};
        tbl[5]  = '{1, 6, 0, 5, 0, 0};
        tbl[6]  = '{1, 7, 0, 6, 1, 0};
        tbl[7]  = '{1, 8, 0, 7, 1, 0};
        tbl[8]  = '{1, 9, 0, 8, 1, 0};
        tbl[9]  = '{0, 0, 0, 8, 1, 1};
        tbl[10] = '{0, 0, 1, 7, 1, 1};
        tbl[11] = '{0, 0, 1, 6, 1, 1};
        tbl[12] = '{0, 0, 1, 5, 0, 1};
        tbl[13] = '{0, 0, 1, 4, 0, 1};
        tbl[14] = '{0, 0, 1, 3, 0, 1};
        tbl[15] = '{0, 0, 1, 2, 0, 1};
        tbl[16] = '{0, 0, 1, 1, 0, 1};
        tbl[17] = '{0, 0, 1, 0, 0, 1};

        for (int c = 0; c < N; c++) hist[c] = '0;
        model_clear();

        // Reset held with arr_valid asserted
        set_in(1'b1, mk(99), 1'b1);
        cur_v = 1'b1;
        repeat (3) begin
            set_in(1'b1, mk(99), 1'b1);
            tick();
        end
        set_in(1'b0, '0, 1'b0);
        rst = 1'b1;

        // Single row alignment
        for (int w = 0; w < NW; w++) r[w*OB +: OB] = OB'(av[w]);
        set_in(1'b1, r, 1'b0);
        tick();
        chk("align_early", tvalid, 0);
        set_in(1'b0, '0, 1'b0);
        tick();
        chk("align_tvalid", tvalid, 1);
        chk("align_tdata", tdata, r);
        chk("align_tlast", tlast, 0);
        chk("tkeep", tkeep, {(W/8){1'b1}});
        drain();

        // Backpressure and overflow
        pulse_clear();
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].v, mk(tbl[i].val), tbl[i].rdy);
            tick();
            chk("bp_count", count, tbl[i].cnt);
            chk("bp_af", almost_full, tbl[i].af);
            chk("bp_ovf", overflow, tbl[i].ovf);
        end

        // Full with simultaneous push and pop
        pulse_clear();
        chk("clr_ovf", overflow, 0);
        for (int i = 0; i < D; i++) begin
            set_in(1'b1, mk(20 + i), 1'b0);
            tick();
        end
        set_in(1'b1, mk(30), 1'b0);
        tick();
        chk("full_count", count, D);
        set_in(1'b0, '0, 1'b1);
        tick();
        chk("fullpp_count", count, D);
        chk("fullpp_ovf", overflow, 0);
        drain();

        // clear mid-packet
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, mk(40 + i), 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b1);
        tick();
        chk("mid_count", count, 3);
        set_in(1'b0, '0, 1'b0);
        pulse_clear();
        chk("clr_count", count, 0);
        chk("clr_tvalid", tvalid, 0);
        chk("clr_ovf2", overflow, 0);
        set_in(1'b1, mk(50), 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0);
        tick();
        chk("clr_next_tvalid", tvalid, 1);
        chk("clr_next_tlast", tlast, 0);
        drain();

        // Async reset mid-stream
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, mk(55 + i), 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0);
        chk("pre_arst_tvalid", tvalid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tvalid", tvalid, 0);
        chk("arst_count", count, 0);
        model_clear();
        tick();
        tick();
        rst = 1'b1;
        set_in(1'b1, mk(60), 1'b0);
        tick();
        chk("arst_lat_early", tvalid, 0);
        set_in(1'b0, '0, 1'b0);
        tick();
        chk("arst_lat_tvalid", tvalid, 1);
        chk("arst_tdata", tdata, mk(60));
        chk("arst_tlast", tlast, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
